// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO feeding a UART transmitter through
// its en/data/busy handshake, reporting fill level and sticky overflow.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        flush,
    input  logic        clr_overflow,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level,
    output logic        overflow,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push;
    logic        drop;
    logic        pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign level = wr_ptr - rd_ptr;

    assign push = wr_en && !full && !flush;
    assign drop = wr_en && full && !flush;
    assign pop  = (state == IDLE) && !empty && !tx_busy && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A dropped push in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_data <= 8'h00;
        end else if (pop) begin
            tx_data <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = ISSUE;
            ISSUE:   state_next = WAIT_HI;
            WAIT_HI: if (tx_busy) state_next = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_en = 1'b0;
        if (state == ISSUE) begin
            tx_en = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, directed corner sequences and a
// randomized run against a queue-based model, plus a DEPTH=4 wrap run.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en, flush, clr_overflow;
    logic [7:0] wr_data;
    logic       full, empty, overflow, tx_en, tx_busy;
    logic [7:0] tx_data;
    logic [4:0] level;

    logic       b_wr_en;
    logic [7:0] b_wr_data;
    logic       b_full, b_empty, b_overflow, b_tx_en, b_tx_busy;
    logic [7:0] b_tx_data;
    logic [2:0] b_level;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut_a (
        .clk(clk), .resetn(resetn),
        .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .clr_overflow(clr_overflow),
        .full(full), .empty(empty), .level(level),
        .overflow(overflow), .tx_en(tx_en),
        .tx_data(tx_data), .tx_busy(tx_busy)
    );

    uart_tx_fifo #(.DEPTH(4)) dut_b (
        .clk(clk), .resetn(resetn),
        .wr_en(b_wr_en), .wr_data(b_wr_data),
        .flush(1'b0), .clr_overflow(1'b0),
        .full(b_full), .empty(b_empty), .level(b_level),
        .overflow(b_overflow), .tx_en(b_tx_en),
        .tx_data(b_tx_data), .tx_busy(b_tx_busy)
    );

    int errors = 0;
    int checks = 0;
    int proto_bad = 0;

    // Serial transmitter model for instance A
    logic       m_busy, line, hold;
    logic [8:0] sh;
    int         nbits, cnt, bit_clks;
    assign tx_busy = m_busy | hold;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_busy <= 1'b0;
            line <= 1'b1;
            sh <= '0;
            nbits <= 0;
            cnt <= 0;
        end else if (!m_busy) begin
            if (tx_en) begin
                m_busy <= 1'b1;
                line <= 1'b0;
                sh <= {1'b1, tx_data};
                nbits <= 9;
                cnt <= bit_clks - 1;
            end
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
        end else if (nbits == 0) begin
            m_busy <= 1'b0;
        end else begin
            line <= sh[0];
            sh <= sh >> 1;
            nbits <= nbits - 1;
            cnt <= bit_clks - 1;
        end
    end

    // Randomly slow consumer for instance B
    logic       b_busy;
    int         b_cnt;
    logic [7:0] recv_b[$];
    assign b_tx_busy = b_busy;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_busy <= 1'b0;
            b_cnt <= 0;
        end else if (b_busy) begin
            if (b_cnt == 0) b_busy <= 1'b0;
            else b_cnt <= b_cnt - 1;
        end else if (b_tx_en) begin
            b_busy <= 1'b1;
            b_cnt <= int'($urandom_range(5));
            recv_b.push_back(b_tx_data);
        end
    end

    logic [7:0] sent_a[$];
    logic       prev_en, b_prev_en;

    always @(negedge clk) begin
        if (resetn) begin
            if (tx_en) sent_a.push_back(tx_data);
            if (tx_en && (prev_en || tx_busy)) proto_bad <= proto_bad + 1;
            if (b_tx_en && (b_prev_en || b_tx_busy)) proto_bad <= proto_bad + 1;
        end
        prev_en <= tx_en;
        b_prev_en <= b_tx_en;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int q;
        q = 0;
        for (int i = 0; i < budget && q < 8; i++) begin
            tick();
            if (!tx_busy && empty && !tx_en) q++;
            else q = 0;
        end
        chk({name, " quiet timeout"}, 32'(q >= 8), 1);
    endtask

    task automatic wait_sent(input string name, input int n, input int budget);
        for (int i = 0; i < budget && sent_a.size() < n; i++) tick();
        chk({name, " sent timeout"}, 32'(sent_a.size() >= n), 1);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       fl;
        logic       cl;
        logic [4:0] lvl;
        logic       fu;
        logic       em;
        logic       ov;
    } vec_t;

    vec_t       tbl[25];
    logic [7:0] m_q[$];
    logic [7:0] m_txd, rx;
    logic       m_ovf, m_ten, m_pend, m_hi;
    logic       w, f, c, b, popm;
    logic [7:0] d;
    int         m_pt, sz, sent_n, maxl, lvl_bad;

    initial begin
        tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i <= 16; i++)
            tbl[i] = '{1'b1, 8'(8'h40 + i), 1'b0, 1'b0,
                       5'(i), 1'(i == 16), 1'b0, 1'b0};
        tbl[17] = '{1'b1, 8'hEE, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 8'hEF, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 8'h77, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 8'h78, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 8'h79, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};

        hold = 1'b0;
        bit_clks = 104;
        wr_en = 0; wr_data = 0; flush = 0; clr_overflow = 0;
        b_wr_en = 0; b_wr_data = 0;
        resetn = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'($urandom_range(1));
            wr_data = 8'($urandom);
            flush = 1'($urandom_range(1));
            clr_overflow = 1'($urandom_range(1));
            b_wr_en = 1'($urandom_range(1));
            tick();
            chk("rst empty", empty, 1);
            chk("rst level", level, 0);
            chk("rst tx_en", tx_en, 0);
            chk("rst tx_data", tx_data, 0);
            chk("rst overflow", overflow, 0);
        end
        wr_en = 0; flush = 0; clr_overflow = 0; b_wr_en = 0;
        resetn = 1'b1;
        tick();

        // Single byte at 115200 baud from 12 MHz
        wr_en = 1; wr_data = 8'hA5;
        tick();
        wr_en = 0;
        chk("single empty", empty, 0);
        chk("single level", level, 1);
        chk("single early en", tx_en, 0);
        tick();
        chk("single tx_en", tx_en, 1);
        chk("single tx_data", tx_data, 8'hA5);
        chk("single level0", level, 0);
        tick();
        chk("single en pulse", tx_en, 0);
        lvl_bad = 0;
        for (int i = 0; i < 10 && line; i++) tick();
        chk("single start seen", line, 0);
        repeat (52) tick();
        chk("single start mid", line, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (104) begin
                tick();
                if (level != 0) lvl_bad++;
            end
            rx[i] = line;
        end
        repeat (104) tick();
        chk("single stop", line, 1);
        chk("single rx byte", rx, 8'hA5);
        chk("single level hold", lvl_bad, 0);
        wait_quiet("single", 400);

        // Table of flag vectors with the transmitter held busy
        hold = 1'b1;
        for (int i = 0; i < 25; i++) begin
            wr_en = tbl[i].we;
            wr_data = tbl[i].wd;
            flush = tbl[i].fl;
            clr_overflow = tbl[i].cl;
            tick();
            chk($sformatf("vec%0d level", i), level, tbl[i].lvl);
            chk($sformatf("vec%0d full", i), full, tbl[i].fu);
            chk($sformatf("vec%0d empty", i), empty, tbl[i].em);
            chk($sformatf("vec%0d ovf", i), overflow, tbl[i].ov);
        end
        wr_en = 0; flush = 0; clr_overflow = 0;

        // Fill and overflow, then drain
        bit_clks = 4;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1; wr_data = 8'(i);
            tick();
            if (i == 15) begin
                chk("fill full", full, 1);
                chk("fill level", level, 16);
                chk("fill ovf early", overflow, 0);
            end
            if (i == 16) begin
                chk("fill ovf", overflow, 1);
                chk("fill level kept", level, 16);
            end
        end
        wr_en = 0;
        clr_overflow = 1;
        tick();
        clr_overflow = 0;
        chk("fill ovf clr", overflow, 0);
        sent_a.delete();
        hold = 1'b0;
        wait_sent("fill", 16, 3000);
        wait_quiet("fill", 400);
        chk("fill sent count", sent_a.size(), 16);
        for (int i = 0; i < sent_a.size() && i < 16; i++)
            chk($sformatf("fill byte%0d", i), sent_a[i], i);

        // Push and pop in the same cycle
        hold = 1'b1;
        sent_a.delete();
        wr_en = 1; wr_data = 8'h50; tick();
        wr_data = 8'h51; tick();
        hold = 1'b0; wr_data = 8'h52;
        tick();
        wr_en = 0;
        chk("pp tx_en", tx_en, 1);
        chk("pp level", level, 2);
        wait_quiet("pp", 400);
        chk("pp count", sent_a.size(), 3);
        for (int i = 0; i < sent_a.size() && i < 3; i++)
            chk($sformatf("pp byte%0d", i), sent_a[i], 8'h50 + i);

        // Flush during byte 2 of 5
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 8'(8'h30 + i); tick();
        end
        wr_en = 0;
        sent_a.delete();
        hold = 1'b0;
        wait_sent("mflush", 2, 400);
        repeat (5) tick();
        flush = 1;
        tick();
        flush = 0;
        chk("mflush empty", empty, 1);
        chk("mflush level", level, 0);
        wait_quiet("mflush", 400);
        chk("mflush count", sent_a.size(), 2);
        if (sent_a.size() >= 2) chk("mflush byte2", sent_a[1], 8'h31);

        // Randomized run against a queue model
        bit_clks = 2;
        m_q.delete();
        m_ovf = 0; m_pend = 0; m_hi = 0; m_ten = 0;
        m_txd = 8'h31; m_pt = 0;
        for (int t = 0; t < 2000; t++) begin
            w = ($urandom_range(99) < 45);
            d = 8'($urandom);
            f = ($urandom_range(99) < 2);
            c = ($urandom_range(99) < 4);
            wr_en = w; wr_data = d; flush = f; clr_overflow = c;
            b = tx_busy;
            sz = m_q.size();
            popm = !m_pend && sz != 0 && !b && !f;
            if (popm) begin
                m_txd = m_q.pop_front();
                m_pend = 1; m_hi = 0; m_pt = t;
            end else if (m_pend && t > m_pt + 1) begin
                if (!m_hi && b) m_hi = 1;
                else if (m_hi && !b) m_pend = 0;
            end
            m_ten = popm;
            if (f) m_q.delete();
            else if (w && sz < DEPTH) m_q.push_back(d);
            if (w && !f && sz == DEPTH) m_ovf = 1;
            else if (c) m_ovf = 0;
            tick();
            chk("rnd level", level, m_q.size());
            chk("rnd full", full, 32'(m_q.size() == DEPTH));
            chk("rnd empty", empty, 32'(m_q.size() == 0));
            chk("rnd ovf", overflow, m_ovf);
            chk("rnd tx_en", tx_en, m_ten);
            chk("rnd tx_data", tx_data, m_txd);
        end
        wr_en = 0; flush = 0; clr_overflow = 0;
        wait_quiet("rnd", 400);

        // DEPTH=4 wrap streaming
        recv_b.delete();
        sent_n = 0; maxl = 0;
        for (int i = 0; i < 4000 && recv_b.size() < 40; i++) begin
            if (sent_n < 40 && !b_full && $urandom_range(3) != 0) begin
                b_wr_en = 1; b_wr_data = 8'(sent_n); sent_n++;
            end else begin
                b_wr_en = 0;
            end
            tick();
            if (int'(b_level) > maxl) maxl = int'(b_level);
        end
        b_wr_en = 0;
        chk("wrap count", recv_b.size(), 40);
        for (int i = 0; i < recv_b.size() && i < 40; i++)
            chk($sformatf("wrap byte%0d", i), recv_b[i], i);
        chk("wrap max level", 32'(maxl <= 4), 1);
        chk("wrap ovf", b_overflow, 0);

        // Reset mid-frame
        hold = 1'b1; bit_clks = 4;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1; wr_data = 8'(8'h60 + i); tick();
        end
        wr_en = 0;
        hold = 1'b0;
        for (int i = 0; i < 20 && !tx_busy; i++) tick();
        chk("mrst busy seen", tx_busy, 1);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mrst tx_en", tx_en, 0);
        chk("mrst tx_data", tx_data, 0);
        chk("mrst empty", empty, 1);
        chk("mrst full", full, 0);
        chk("mrst level", level, 0);
        chk("mrst ovf", overflow, 0);
        tick();
        resetn = 1'b1;
        repeat (3) tick();
        chk("mrst idle en", tx_en, 0);

        chk("protocol", proto_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-wide transmit buffer sitting directly upstream of the UART transmitter. The CPU/peripheral bus side pushes bytes at any rate. The block stores them in a circular FIFO and feeds them to the transmitter one at a time through the transmitter's `en` / `data` / `busy` handshake. The block also reports FIFO level and a sticky overflow flag for the UART status register.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `AW`, `$clog2(DEPTH)`: local pointer width; not overridable.

Ports:
- `clk`  in  1: system clock; all logic is on the rising edge.
- `resetn`  in  1: asynchronous active-low reset.
- `wr_en`  in  1: push `wr_data` this cycle.
- `wr_data`  in  8: byte to push.
- `flush`  in  1: synchronous FIFO clear.
- `clr_overflow`  in  1: clear the sticky overflow flag.
- `full`  out  1: FIFO holds `DEPTH` entries.
- `empty`  out  1: FIFO holds 0 entries.
- `level`  out  AW+1: current entry count, range 0..`DEPTH`.
- `overflow`  out  1: sticky; set when a push is dropped because the FIFO is full.
- `tx_en`  out  1: one-cycle start pulse to the transmitter (its `uart_tx_en`).
- `tx_data`  out  8: byte for the transmitter (its `uart_tx_data`); valid while `tx_en` is high.
- `tx_busy`  in  1: transmitter busy (its `uart_tx_busy`).

## Operation
- Storage: `DEPTH` x 8 register array. Read and write pointers are AW+1 bits; the MSB is the wrap bit.
  - `full` = pointers differ only in the MSB.
  - `empty` = pointers are equal.
  - `level` = `wr_ptr - rd_ptr`, modulo 2^(AW+1).
- Push: when `wr_en` is high and `full` is low, the byte is written at `wr_ptr[AW-1:0]` and `wr_ptr` increments, wrapping naturally.
- Push while full: the byte is dropped, pointers are unchanged, and `overflow` is set. `full` is the registered value at the start of the cycle, so a pop in the same cycle does not make room.
- `overflow` clear: `clr_overflow` clears it. A set in the same cycle wins over the clear.
- `flush`: sets `rd_ptr` to `wr_ptr`, so the FIFO becomes empty.
  - Flush wins over a simultaneous push. The pushed byte is discarded and `overflow` is not set.
  - Flush does not touch the feeder FSM. A byte already issued completes normally.
- Feeder FSM, 2-bit state:
  - IDLE: if `!empty && !tx_busy && !flush`, then load `tx_data` from `mem[rd_ptr]`, increment `rd_ptr`, drive `tx_en` to 1, and go to ISSUE.
  - ISSUE: drive `tx_en` to 0 and go to WAIT_HI.
  - WAIT_HI: stay until `tx_busy` is 1, then go to WAIT_LO.
  - WAIT_LO: stay until `tx_busy` is 0, then go to IDLE.
  - Unused encoding: go to IDLE.
- Push and pop in the same cycle leave `level` unchanged. A push into an empty FIFO is never popped in the same cycle.
- `tx_data` holds its value after `tx_en` falls and updates only on the next pop.

## Timing
- Reset (asynchronous, `resetn` low):
  - `tx_en` = 0, `tx_data` = 0x00.
  - `full` = 0, `empty` = 1, `level` = 0, `overflow` = 0.
  - FSM = IDLE, pointers = 0. Array contents are don't-care.
- All outputs are registered, or are combinational from registers only. There is no input-to-output combinational path.
- Push into an empty FIFO at edge N:
  - `empty` falls after edge N.
  - Pop at edge N+1: `tx_en` is high for exactly the cycle after N+1, and `level` returns to 0 after N+1.
  - The transmitter latches at edge N+2, and `tx_busy` rises after N+2.
- Gap between frames: `tx_busy` falls after edge M. The FSM enters IDLE at M+1 and issues the next `tx_en` at M+2 if data is pending.
- `tx_en` is never high in two consecutive cycles and is never asserted while `tx_busy` is high.
- Reset asserted mid-frame: the FIFO empties and the FSM returns to IDLE immediately. The transmitter is reset by the same `resetn`.

## Test plan
- Reset check: hold `resetn` low with random inputs → `empty` = 1, `level` = 0, `tx_en` = 0, `tx_data` = 0x00, `overflow` = 0.
- Single byte: push 0xA5 with an idle transmitter model (115200 baud, 12 MHz) → one `tx_en` pulse 1 cycle after the push with `tx_data` = 0xA5. The line shows start, 0xA5 LSB first, then stop. `level` is 0 throughout transmission.
- Fill and overflow: hold `tx_busy` = 1 and push 17 bytes 0x00..0x10 → `full` = 1 and `level` = 16 after the 16th push. The 17th push sets `overflow`. Release `tx_busy` → bytes 0x00..0x0F are sent in order and 0x10 is never sent.
- Simultaneous events:
  - Push and pop in the same cycle → `level` is unchanged.
  - `clr_overflow` in the same cycle as an overflowing push → `overflow` stays 1.
  - `flush` with `wr_en` → `empty` = 1 and `overflow` = 0.
- Pointer wrap: stream 40 bytes with a counting pattern through a DEPTH = 4 instance → all 40 bytes are received in order and `level` never exceeds 4.
- Mid-frame flush and reset:
  - `flush` during byte 2 of 5 → byte 2 completes and bytes 3..5 are never sent.
  - Separately, `resetn` low mid-frame → all outputs take their reset values within the same cycle.
